// File: rtl/mem_pkg.sv
// Shared types and helpers for dual_port_mem: port FSM states and the
// address alignment/range check used by both ports.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } port_state_e;

  localparam int DATA_W_DFLT = 32;
  localparam int STRB_W      = DATA_W_DFLT / 8;

  // limit is the array size in bytes; widened to 33 bits so addresses near 2^32 compare correctly
  function automatic logic addr_err(input logic [31:0] addr, input logic [32:0] limit);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/dual_port_mem_ctrl.sv
// Per-port handshake controller for dual_port_mem: IDLE/WAIT/DONE FSM,
// wait-state counter and operand latches; flags the edge on which the access commits.
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  commit_o,
  output logic                  ack_o,
  output logic                  we_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic [31:0]           addr_o,
  output logic [DATA_W-1:0]     wdata_o
);

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  port_state_e           state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [31:0]           addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  accept;

  assign accept = req_i && (state_q != WAIT);
  assign ack_o  = (state_q == DONE);

  // With no wait states the accept edge is also the commit edge, so the live operands are used.
  assign commit_o = (WAIT_STATES == 0) ? accept : ((state_q == WAIT) && (cnt_q == 4'd0));
  assign we_o     = (WAIT_STATES == 0) ? we_i    : we_q;
  assign wstrb_o  = (WAIT_STATES == 0) ? wstrb_i : wstrb_q;
  assign addr_o   = (WAIT_STATES == 0) ? addr_i  : addr_q;
  assign wdata_o  = (WAIT_STATES == 0) ? wdata_i : wdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (req_i) begin
            if (WAIT_STATES == 0) begin
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= DONE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= we_i;
      wstrb_q <= wstrb_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

endmodule

// File: rtl/dual_port_mem.sv
// Dual-port instruction/data memory with wait states and address-error reporting.
// Define MEM_WSTRB_EN to honour d_wstrb per byte lane; otherwise writes update the full word.
module dual_port_mem
  import mem_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic                  i_ack,
  output logic [DATA_W-1:0]     i_data,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  input  logic [31:0]           d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam int          SW    = DATA_W / 8;
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'(SW);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              i_commit, i_we_c, i_err_c;
  logic [SW-1:0]     i_wstrb_c;
  logic [31:0]       i_addr_c;
  logic [DATA_W-1:0] i_wdata_c;
  logic [AW-1:0]     i_idx;

  logic              d_commit, d_we_c, d_err_c, d_wr;
  logic [SW-1:0]     d_wstrb_c, strb_eff;
  logic [31:0]       d_addr_c;
  logic [DATA_W-1:0] d_wdata_c, d_old, d_merged;
  logic [AW-1:0]     d_idx;

  logic unused_i_ctrl;

  mem_port_ctrl #(.DATA_W(DATA_W), .WAIT_STATES(WAIT_STATES)) u_i_ctrl (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (i_req),
    .we_i     (1'b0),
    .wstrb_i  ({SW{1'b0}}),
    .addr_i   (i_addr),
    .wdata_i  ({DATA_W{1'b0}}),
    .commit_o (i_commit),
    .ack_o    (i_ack),
    .we_o     (i_we_c),
    .wstrb_o  (i_wstrb_c),
    .addr_o   (i_addr_c),
    .wdata_o  (i_wdata_c)
  );

  mem_port_ctrl #(.DATA_W(DATA_W), .WAIT_STATES(WAIT_STATES)) u_d_ctrl (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (d_req),
    .we_i     (d_we),
    .wstrb_i  (d_wstrb),
    .addr_i   (d_addr),
    .wdata_i  (d_wdata),
    .commit_o (d_commit),
    .ack_o    (d_ack),
    .we_o     (d_we_c),
    .wstrb_o  (d_wstrb_c),
    .addr_o   (d_addr_c),
    .wdata_o  (d_wdata_c)
  );

  assign unused_i_ctrl = ^{i_we_c, i_wstrb_c, i_wdata_c};

  assign i_err_c = addr_err(i_addr_c, LIMIT);
  assign d_err_c = addr_err(d_addr_c, LIMIT);
  assign i_idx   = i_addr_c[AW+1:2];
  assign d_idx   = d_addr_c[AW+1:2];
  assign d_wr    = d_commit && d_we_c && !d_err_c;

`ifdef MEM_WSTRB_EN
  assign strb_eff = d_wstrb_c;
`else
  assign strb_eff = {SW{1'b1}};
`endif

  // The merged word is both the write value and the write-first bypass for a colliding fetch.
  always_comb begin
    d_old    = mem_q[d_idx];
    d_merged = d_old;
    for (int k = 0; k < SW; k++) begin
      if (strb_eff[k]) d_merged[k*8 +: 8] = d_wdata_c[k*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (d_wr) mem_q[d_idx] <= d_merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_data  <= '0;
      i_err   <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
    end else begin
      if (i_commit) begin
        i_err <= i_err_c;
        if (i_err_c)                   i_data <= '0;
        else if (d_wr && d_idx == i_idx) i_data <= d_merged;
        else                           i_data <= mem_q[i_idx];
      end
      if (d_commit) begin
        d_err   <= d_err_c;
        d_rdata <= (d_err_c || d_we_c) ? '0 : d_old;
      end
    end
  end

endmodule
